// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and the default datapath width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_NONE = 3'd0;
  localparam logic [2:0] MD_MULT = 3'd1;
  localparam logic [2:0] MD_DIV  = 3'd2;
  localparam logic [2:0] MD_MTHI = 3'd3;
  localparam logic [2:0] MD_MTLO = 3'd4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation; yields operand magnitudes at latch
// time and re-applies result signs in the FIX state.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  logic signed [W-1:0] val_s;

  assign val_s = signed'(val);
  assign res   = neg ? unsigned'(-val_s) : val;

endmodule

// File: rtl/md_iter_unit.sv
// Iterative MULT/DIV engine holding architectural HI/LO: one bit per cycle over
// magnitudes (shift-add multiply, restoring divide), then a sign-fix write.
module md_iter_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic             is_sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   rawa_q, rawa_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  md_sign_fix #(.W(WIDTH)) u_mag_a (
    .val (a),
    .neg (is_sign & a[WIDTH-1]),
    .res (mag_a)
  );

  md_sign_fix #(.W(WIDTH)) u_mag_b (
    .val (b),
    .neg (is_sign & b[WIDTH-1]),
    .res (mag_b)
  );

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val (acc_q),
    .neg (neg_res_q),
    .res (prod_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val (acc_q[WIDTH-1:0]),
    .neg (neg_res_q),
    .res (quo_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val (acc_q[2*WIDTH-1:WIDTH]),
    .neg (neg_rem_q),
    .res (rem_fix)
  );

  // One iteration step: acc holds {upper, lower} for both operations
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rawa_d    = rawa_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          if (func == MD_MTHI) begin
            hi_d = a;
          end else if (func == MD_MTLO) begin
            lo_d = a;
          end else if (func == MD_MULT || func == MD_DIV) begin
            acc_d     = {{WIDTH{1'b0}}, mag_a};
            opb_d     = mag_b;
            rawa_d    = a;
            neg_res_d = is_sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_sign & a[WIDTH-1];
            is_div_d  = (func == MD_DIV);
            dz_d      = (func == MD_DIV) && (b == '0);
            cnt_d     = '0;
            state_d   = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            lo_d = '1;
            hi_d = rawa_q;
          end else if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase

    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      rawa_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rawa_q    <= rawa_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit: an arithmetic reference model checked every
// cycle, plus hand-computed HI/LO values for each directed scenario.
module tb_md_iter_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func = MD_NONE;
  logic        is_sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  md_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .func    (func),
    .is_sign (is_sign),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} computed with plain wide arithmetic
  function automatic logic [63:0] md_ref(input logic [2:0] f, input logic s,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    if (f == MD_MULT) begin
      if (s) p = 64'(sx * sy);
      else   p = {32'h0, x} * {32'h0, y};
      return p;
    end
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start && !flush) begin
          if (func == MD_MTHI) m_hi <= a;
          else if (func == MD_MTLO) m_lo <= a;
          else if (func == MD_MULT || func == MD_DIV) begin
            m_rem <= 33;
            {p_hi, p_lo} <= md_ref(func, is_sign, a, b);
          end
        end
      end else if (flush) begin
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_rem != 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] xa,
                       input logic [31:0] xb);
    tick();
    start = 1'b1; func = f; is_sign = s; a = xa; b = xb;
    tick();
    start = 1'b0; func = MD_NONE;
  endtask

  task automatic wait_done(input string name, output int nbusy);
    bit got;
    got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) nbusy++;
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic s,
                        input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    issue(f, s, xa, xb);
    wait_done(name, nb);
    chk({name, "_busy_cycles"}, 64'(nb), 64'd33);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int nb;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;

    run_op("umul_max", MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("sdiv_m7_2", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("smul_m1_m1", MD_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("udiv_100_7", MD_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_zero", MD_DIV, 1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("sdiv_zero_neg", MD_DIV, 1'b1, 32'h8765_4321, 32'h0, 32'h8765_4321, 32'hFFFF_FFFF);
    run_op("sdiv_ovf", MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Back-to-back MTHI then MTLO
    tick();
    start = 1'b1; func = MD_MTHI; a = 32'hCAFE_0000;
    tick();
    chk("mthi_hi", 64'(hi), 64'h0000_0000_CAFE_0000);
    chk("mthi_busy", 64'(busy), 64'd0);
    func = MD_MTLO; a = 32'h0000_BEEF;
    tick();
    chk("mtlo_lo", 64'(lo), 64'h0000_0000_0000_BEEF);
    chk("mtlo_done", 64'(done), 64'd0);
    start = 1'b0; func = MD_NONE;

    // Flush in IDLE drops a simultaneous MTHI
    tick();
    start = 1'b1; flush = 1'b1; func = MD_MTHI; a = 32'hDEAD_DEAD;
    tick();
    start = 1'b0; flush = 1'b0; func = MD_NONE;
    chk("idle_flush_hi", 64'(hi), 64'h0000_0000_CAFE_0000);

    // Flush mid-multiply, then reissue
    issue(MD_MULT, 1'b0, 32'd3, 32'd5);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h0000_0000_CAFE_0000);
    chk("flush_lo", 64'(lo), 64'h0000_0000_0000_BEEF);
    run_op("mul_after_flush", MD_MULT, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);

    // Start held high with changing operands while busy
    tick();
    start = 1'b1; func = MD_MULT; is_sign = 1'b0; a = 32'd6; b = 32'd7;
    tick();
    a = 32'd100; b = 32'd100;
    repeat (20) tick();
    start = 1'b0; func = MD_NONE;
    wait_done("held_start", nb);
    chk("held_start_lo", 64'(lo), 64'd42);
    chk("held_start_hi", 64'(hi), 64'd0);

    // Reset mid-operation
    issue(MD_MULT, 1'b0, 32'd9, 32'd9);
    repeat (18) tick();
    rst = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    repeat (40) tick();
    chk("midrst_no_done", 64'(done), 64'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Iterative multiply/divide responder for the EX stage. EX issues one request with a start pulse; this block computes the result over multiple cycles and holds the architectural HI/LO registers.
- Replaces the single-cycle multiply/divide path. The hazard unit uses busy to stall EX while an operation is in flight.
- Also services MTHI/MTLO writes and returns HI/LO for MFHI/MFLO writeback.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low: state is cleared on a posedge clk where rst==0.
- start  in  1  request strobe from EX; sampled only when busy==0.
- func  in  3  operation code, encoding taken from the package.
- is_sign  in  1  1 = signed MULT/DIV, 0 = unsigned.
- a  in  WIDTH  forwarded rs value (EX f_rd1).
- b  in  WIDTH  forwarded rt value (EX f_rd2).
- flush  in  1  abort the in-flight operation; HI/LO are left unchanged.
- busy  out  1  operation in flight; EX must hold the next MD request.
- done  out  1  one-cycle pulse when HI/LO were just updated by MULT/DIV.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all working registers=0. Reset mid-operation discards the operation.
- States:
  - IDLE: waits for start.
  - CALC: performs 32 iterations.
  - FIX: applies sign correction and writes HI/LO, then returns to IDLE.
- IDLE with start=1, sampled at edge E0:
  - MD_MTHI: hi<=a. Stays IDLE; busy stays 0; no done pulse.
  - MD_MTLO: lo<=a. Stays IDLE; busy stays 0; no done pulse.
  - MD_MULT / MD_DIV: latch operand magnitudes, result sign(s), op and divide-by-zero flag; counter<=0; go to CALC.
  - MD_NONE or any undefined code: no effect.
- CALC:
  - MULT: radix-2 shift-add on the magnitudes, 2*WIDTH-bit product register.
  - DIV: restoring division, one quotient bit per cycle.
  - Each of edges E1..E32 performs one iteration. At E32 (counter==WIDTH-1) the state goes to FIX.
- FIX, edge E33:
  - If signed, negate results: product negated if a xor b negative; quotient negated if a xor b negative; remainder takes the sign of a.
  - Write {hi,lo}. For DIV, lo=quotient and hi=remainder.
  - done=1 for exactly the cycle after E33; go to IDLE.
- busy is registered: 1 from after E0 through the cycle after E33 ends, i.e. 33 cycles. busy is 0 in the cycle done is high, so a new start may be accepted at E34.
- Divide by zero: still takes the full 33 cycles. Result lo=all-ones, hi=a (raw, not sign-fixed), regardless of is_sign.
- Signed overflow 0x80000000/-1: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and must be preserved.
- start while busy=1 is ignored; the request is not queued.
- flush:
  - In CALC or FIX: go to IDLE next edge, busy<=0, no done, hi/lo unchanged.
  - In IDLE: any simultaneous start is dropped.
  - flush has priority over start and over the FIX write.
- Simultaneous rst==0 and flush: reset wins.
- hi/lo change only at: reset, MTHI/MTLO in IDLE, or the FIX edge.

Decomposition:
- Shared package md_pkg holds:
  - MD_NONE=3'd0, MD_MULT=3'd1, MD_DIV=3'd2, MD_MTHI=3'd3, MD_MTLO=3'd4;
  - state encoding MD_IDLE/MD_CALC/MD_FIX;
  - the WIDTH default.
- One sub-module is natural: md_sign_fix, combinational magnitude/negation helper, used at operand latch and in FIX.

Test Plan:
- Unsigned MULT, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- Signed DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Signed MULT -1*-1 -> hi=0, lo=1.
- DIV by zero, a=0x12345678, b=0 -> 33 cycles, then lo=0xFFFFFFFF, hi=0x12345678. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xCAFE0000, then MTLO a=0x0000BEEF on the next cycle -> hi/lo update one edge after each start; busy and done stay 0.
- Start MULT 3*5, assert flush at cycle 10 -> busy drops next cycle, no done, hi/lo keep their prior values. A new MULT issued next cycle yields lo=15, hi=0.
- Start MULT, hold start=1 with different operands while busy -> only the first result appears. rst=0 at cycle 20 -> busy=0, hi=lo=0 after that edge.
